countdown_timer: RTL

//  Loadable down-counter timer. It is the decrementing counterpart of the up-counter.

---
 rtl/countdown_timer_pkg.sv | 12 +
 rtl/countdown_timer.sv | 79 +++++++
 2 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default width.
package countdown_timer_pkg;

    // IDLE/RUN encoding shared with the companion up-counter
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned SIZE_DEFAULT = 4;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter timer with one-shot and auto-reload modes.
// Loads N from data, decrements on enabled cycles and emits a one-cycle tc
// pulse on the N-th enabled edge. A load of 0 behaves like a load of 1.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned SIZE = SIZE_DEFAULT
) (
    input  logic            clk_i,
    input  logic            r_ni,
    input  logic            start_i,
    input  logic            stop_i,
    input  logic            e_i,
    input  logic            reload_i,
    input  logic [SIZE-1:0] data_i,
    output logic            busy_o,
    output logic            tc_o,
    output logic [SIZE-1:0] count_o
);

    localparam logic [SIZE-1:0] ONE = {{(SIZE-1){1'b0}}, 1'b1};

    state_e          state_q;
    logic [SIZE-1:0] count_q;
    logic [SIZE-1:0] load_val_q;
    logic            busy_q;
    logic            tc_q;

    logic [SIZE-1:0] count_dec_d;
    logic            terminal_d;

    // Next-count and terminal-detect: full-width unsigned compare, so 0 and 1 both expire
    always_comb begin
        count_dec_d = count_q - ONE;
        terminal_d  = (count_q <= ONE);
    end

    // State, count, reload value and registered outputs; priority stop > start > enable
    always_ff @(posedge clk_i or negedge r_ni) begin
        if (!r_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            load_val_q <= '0;
            busy_q     <= 1'b0;
            tc_q       <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (stop_i) begin
                // Abort keeps the count visible for inspection
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else if (start_i) begin
                // Load (or restart) discards any count in progress without a tc
                count_q    <= data_i;
                load_val_q <= data_i;
                busy_q     <= 1'b1;
                state_q    <= ST_RUN;
            end else if (state_q == ST_RUN && e_i) begin
                if (terminal_d) begin
                    tc_q <= 1'b1;
                    if (reload_i) begin
                        count_q <= load_val_q;
                    end else begin
                        count_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end else begin
                    count_q <= count_dec_d;
                end
            end
        end
    end

    assign busy_o  = busy_q;
    assign tc_o    = tc_q;
    assign count_o = count_q;

endmodule
